// File: rtl/sr_lru_unit_pkg.sv
// Shared types and constants for the sr_cpu LRU tracker (sr_lru_unit / sr_lru_store).
package sr_lru_unit_pkg;

  localparam int unsigned STAT_W = 16;

  localparam logic LRU_OP_PUSH = 1'b0;
  localparam logic LRU_OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } lru_state_t;

  // Saturating increment for the hit/miss statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sr_lru_store.sv
// Recency-ordered register array: insert at slot 0 while shifting slots 1..hi down by one,
// plus one asynchronous read port.
module sr_lru_store #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     i_shift_en,
  input  logic [$clog2(DEPTH)-1:0] i_shift_hi,
  input  logic [WIDTH-1:0]         i_ins_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [WIDTH-1:0]         o_rd_data_c
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // All moves happen in parallel on one edge; slots above hi keep their value.
  always_ff @(posedge clk) begin
    if (i_shift_en) begin
      r_mem[0] <= i_ins_data;
      for (int unsigned j = 1; j < DEPTH; j++) begin
        if (IW'(j) <= i_shift_hi) begin
          r_mem[j] <= r_mem[j-1];
        end
      end
    end
  end

  assign o_rd_data_c = r_mem[i_rd_idx];

endmodule

// File: rtl/sr_lru_unit.sv
// Multi-cycle LRU tracker for lru.push / lru.pop: linear search, single-cycle shift-insert.
// Optional statistics counters built only when SR_LRU_STATS_EN is defined.
module sr_lru_unit
  import sr_lru_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic                   req_op,
  input  logic [WIDTH-1:0]       req_data,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_hit,
  output logic                   resp_evict,
  output logic                   resp_err,
  output logic [$clog2(DEPTH):0] count,
  output logic [STAT_W-1:0]      hit_cnt,
  output logic [STAT_W-1:0]      miss_cnt
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  lru_state_t       r_state;
  logic             r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_evict_data;
  logic [IW-1:0]    r_idx;
  logic             r_hit;
  logic             r_evict;
  logic [CW-1:0]    r_count;

  logic [IW-1:0]    w_rd_idx;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_shift_en;
  logic [IW-1:0]    w_shift_hi;
  logic             w_full;
  logic             w_match;
  logic             w_last;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_match    = (w_rd_data == r_data);
  assign w_last     = (CW'(r_idx) == r_count - CW'(1));
  assign w_shift_en = (r_state == ST_SHIFT);
  assign count      = r_count;

  // Read port: search slot, old LRU slot (eviction capture), or pop target.
  always_comb begin
    w_rd_idx = r_idx;
    case (r_state)
      ST_SHIFT: w_rd_idx = IW'(DEPTH - 1);
      ST_DONE:  w_rd_idx = IW'(r_count - CW'(1));
      default:  w_rd_idx = r_idx;
    endcase
  end

  // Hit: move the hit slot to the front. Miss: shift everything valid, dropping LRU when full.
  always_comb begin
    w_shift_hi = r_count[IW-1:0];
    if (r_hit) begin
      w_shift_hi = r_idx;
    end else if (w_full) begin
      w_shift_hi = IW'(DEPTH - 1);
    end
  end

  sr_lru_store #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_store (
    .clk         (clk),
    .i_shift_en  (w_shift_en),
    .i_shift_hi  (w_shift_hi),
    .i_ins_data  (r_data),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data_c (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_hit     <= 1'b0;
      resp_evict   <= 1'b0;
      resp_err     <= 1'b0;
      r_count      <= '0;
      r_op         <= LRU_OP_PUSH;
      r_data       <= '0;
      r_evict_data <= '0;
      r_idx        <= '0;
      r_hit        <= 1'b0;
      r_evict      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op      <= req_op;
            r_data    <= req_data;
            r_idx     <= '0;
            r_hit     <= 1'b0;
            r_evict   <= 1'b0;
            req_ready <= 1'b0;
            if (req_op == LRU_OP_POP) begin
              r_state <= ST_DONE;
            end else if (r_count == '0) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_SEARCH;
            end
          end
        end
        ST_SEARCH: begin
          if (w_match) begin
            r_hit   <= 1'b1;
            r_state <= ST_SHIFT;
          end else if (w_last) begin
            r_state <= ST_SHIFT;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_SHIFT: begin
          if (!r_hit) begin
            if (w_full) begin
              r_evict      <= 1'b1;
              r_evict_data <= w_rd_data;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          r_state    <= ST_IDLE;
          if (r_op == LRU_OP_PUSH) begin
            resp_err   <= 1'b0;
            resp_hit   <= r_hit;
            resp_evict <= r_evict;
            resp_data  <= r_evict ? r_evict_data : '0;
          end else begin
            resp_hit   <= 1'b0;
            resp_evict <= 1'b0;
            if (r_count == '0) begin
              resp_err  <= 1'b1;
              resp_data <= '0;
            end else begin
              resp_err  <= 1'b0;
              resp_data <= w_rd_data;
              r_count   <= r_count - CW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SR_LRU_STATS_EN
  logic [STAT_W-1:0] r_hit_cnt;
  logic [STAT_W-1:0] r_miss_cnt;

  // One count per completed push, updated alongside the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if ((r_state == ST_DONE) && (r_op == LRU_OP_PUSH)) begin
      if (r_hit) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end else begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
